// File: rtl/stream_argmax.sv
// stream_argmax -- reduces each frame of N serialized class scores to the
// winning class index and its score, and emits one result word per frame.
//
// Ports:
//   clock            system clock
//   reset            synchronous, active-high reset
//   in_data          packed score word, lane d at [d*DATA_BITS +: DATA_BITS]
//   in_valid         in_data valid
//   upstream_stall   block cannot accept (high while a result is pending)
//   out_data         [15:0] winning index, [23:16] winning score (zero-ext),
//                    [31:24] frame sequence number or zero
//   out_valid        result valid
//   downstream_stall consumer not ready; result held while high
//
// Optional feature: define STREAM_ARGMAX_FRAME_SEQ_EN to place an 8-bit
// wrapping frame sequence counter in out_data[31:24]. Without it those bits
// are constant zero. Handshake and latency are identical either way.
module stream_argmax #(
  parameter int N             = 10,
  parameter int DATA_BITS     = 8,
  parameter int DATA_PER_WORD = 1,
  parameter int WORD_SIZE     = 32,
  parameter int SIGNED        = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 upstream_stall,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 downstream_stall
);

  // Count must hold N+DATA_PER_WORD-1 without wrapping.
  localparam int CW = $clog2(N + DATA_PER_WORD);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_EMIT  = 1'b1;

  // Flipping the sign bit maps two's complement onto offset binary, so one
  // unsigned comparator serves both orderings.
  localparam logic [DATA_BITS-1:0] SIGN_FLIP =
    (SIGNED != 0) ? (DATA_BITS'(1) << (DATA_BITS - 1)) : '0;

  logic [0:0]           r_state;
  logic [CW-1:0]        r_count;
  logic [DATA_BITS-1:0] r_max;
  logic [15:0]          r_idx;

  logic [DATA_BITS-1:0] w_max;
  logic [15:0]          w_idx;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic [7:0]           w_seq;
  logic                 w_unused_in;

  assign w_accept    = in_valid && (r_state == ST_ACCUM);
  assign w_count_nxt = r_count + CW'(DATA_PER_WORD);
  assign w_last      = (w_count_nxt >= CW'(N));

  // Lanes are chained in ascending order; a strict greater-than keeps the
  // lowest index on ties. Lanes past N are padding and are skipped.
  always_comb begin : lane_chain
    logic [15:0]          gi;
    logic [DATA_BITS-1:0] lane;
    gi    = '0;
    lane  = '0;
    w_max = r_max;
    w_idx = r_idx;
    for (int d = 0; d < DATA_PER_WORD; d++) begin
      gi   = 16'(r_count) + 16'(d);
      lane = in_data[d*DATA_BITS +: DATA_BITS];
      if (gi < 16'(N)) begin
        if ((gi == 16'd0) || ((lane ^ SIGN_FLIP) > (w_max ^ SIGN_FLIP))) begin
          w_max = lane;
          w_idx = gi;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_ACCUM;
      r_count <= '0;
      r_max   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_max   <= w_max;
            r_idx   <= w_idx;
            r_count <= w_count_nxt;
            if (w_last) r_state <= ST_EMIT;
          end
        end
        default: begin
          // r_max/r_idx are frozen here and double as the result register.
          if (!downstream_stall) begin
            r_state <= ST_ACCUM;
            r_count <= '0;
          end
        end
      endcase
    end
  end

`ifdef STREAM_ARGMAX_FRAME_SEQ_EN
  logic [7:0] r_seq;
  always_ff @(posedge clock) begin
    if (reset)
      r_seq <= '0;
    else if ((r_state == ST_EMIT) && !downstream_stall)
      r_seq <= r_seq + 8'd1;
  end
  assign w_seq = r_seq;
`else
  assign w_seq = 8'h00;
`endif

  assign upstream_stall = (r_state == ST_EMIT);
  assign out_valid      = (r_state == ST_EMIT);
  assign out_data       = WORD_SIZE'({w_seq, 8'(r_max), r_idx});

  // Lanes above DATA_PER_WORD*DATA_BITS carry nothing.
  assign w_unused_in = ^in_data;

endmodule

// File: tb/tb_stream_argmax.sv
// Testbench for stream_argmax. Two instances: A (N=10, 1 lane, signed) and
// B (N=10, 4 lanes, unsigned). Results are checked against an integer
// argmax reference over the frame's value list.
module tb_stream_argmax;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] idata  [2];
  logic        ival   [2];
  logic        dstall [2];
  logic [31:0] od     [2];
  logic        ov     [2];
  logic        us     [2];

  logic [31:0] od_a, od_b;
  logic        ov_a, ov_b, us_a, us_b;

  stream_argmax #(.N(10), .DATA_BITS(8), .DATA_PER_WORD(1), .WORD_SIZE(32), .SIGNED(1)) u_a (
    .clock(clock), .reset(reset), .in_data(idata[0]), .in_valid(ival[0]),
    .upstream_stall(us_a), .out_data(od_a), .out_valid(ov_a), .downstream_stall(dstall[0]));

  stream_argmax #(.N(10), .DATA_BITS(8), .DATA_PER_WORD(4), .WORD_SIZE(32), .SIGNED(0)) u_b (
    .clock(clock), .reset(reset), .in_data(idata[1]), .in_valid(ival[1]),
    .upstream_stall(us_b), .out_data(od_b), .out_valid(ov_b), .downstream_stall(dstall[1]));

  assign od[0] = od_a; assign ov[0] = ov_a; assign us[0] = us_a;
  assign od[1] = od_b; assign ov[1] = ov_b; assign us[1] = us_b;

  int n_chk = 0;
  int n_fail = 0;
  int exp_seq [2];
  int dpw_tab [2] = '{1, 4};
  bit sgn_tab [2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Reference: plain integer argmax, first occurrence wins ties.
  function automatic logic [23:0] ref_argmax(input logic [7:0] v [10], input bit sgn);
    int best, bi, x;
    best = 0; bi = 0;
    for (int i = 0; i < 10; i++) begin
      x = sgn ? int'($signed(v[i])) : int'(v[i]);
      if (i == 0 || x > best) begin best = x; bi = i; end
    end
    return {v[bi], 16'(bi)};
  endfunction

  function automatic logic [7:0] seq_byte(input int sel);
`ifdef STREAM_ARGMAX_FRAME_SEQ_EN
    return 8'(exp_seq[sel]);
`else
    return 8'h00;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin ival[s] = 1'b0; dstall[s] = 1'b0; end
    @(negedge clock);
    reset = 1'b0;
    for (int s = 0; s < 2; s++) begin
      exp_seq[s] = 0;
      chk("rst_out_valid", 32'(ov[s]), 32'd0);
      chk("rst_ustall", 32'(us[s]), 32'd0);
      chk("rst_out_data", od[s], 32'd0);
    end
  endtask

  // Streams one frame, checks the result one cycle after the last accept,
  // optionally holds downstream_stall while offering junk input, releases.
  task automatic send_frame(input int sel, input logic [7:0] v [10], input logic [7:0] pad,
                            input int stall_cyc, input bit gaps);
    int dpw, nw, w, guard;
    logic [31:0] word, exp;
    dpw = dpw_tab[sel];
    nw = (10 + dpw - 1) / dpw;
    w = 0; guard = 0;
    while (w < nw && guard < 200) begin
      @(negedge clock);
      guard++;
      chk("accum_out_valid", 32'(ov[sel]), 32'd0);
      chk("accum_ustall", 32'(us[sel]), 32'd0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        ival[sel] = 1'b0;
        idata[sel] = $urandom;
      end else begin
        word = '0;
        for (int d = 0; d < dpw; d++)
          word[d*8 +: 8] = (w*dpw + d < 10) ? v[w*dpw + d] : pad;
        ival[sel] = 1'b1;
        idata[sel] = word;
        if (!us[sel]) w++;
      end
    end
    if (w < nw) chk("accept_timeout", 32'(w), 32'(nw));
    exp = {seq_byte(sel), ref_argmax(v, sgn_tab[sel])};
    @(negedge clock);
    ival[sel] = 1'b0;
    chk("result_valid", 32'(ov[sel]), 32'd1);
    chk("emit_ustall", 32'(us[sel]), 32'd1);
    chk("result_data", od[sel], exp);
    dstall[sel] = (stall_cyc > 0);
    for (int k = 0; k < stall_cyc; k++) begin
      ival[sel] = 1'b1;
      idata[sel] = $urandom;
      @(negedge clock);
      chk("hold_valid", 32'(ov[sel]), 32'd1);
      chk("hold_ustall", 32'(us[sel]), 32'd1);
      chk("hold_data", od[sel], exp);
    end
    ival[sel] = 1'b0;
    dstall[sel] = 1'b0;
    exp_seq[sel] = (exp_seq[sel] + 1) % 256;
  endtask

  logic [7:0] v [10];

  task automatic rand_frame();
    for (int i = 0; i < 10; i++) v[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      ival[s] = 1'b0; dstall[s] = 1'b0; idata[s] = '0; exp_seq[s] = 0;
    end
    repeat (2) @(negedge clock);
    do_reset();

    // Mixed signed frame: first 9 at index 3 wins over the later 9.
    v = '{8'd3, 8'd7, 8'hFE, 8'd9, 8'd9, 8'd0, 8'd1, 8'h80, 8'd5, 8'd4};
    send_frame(0, v, 8'h00, 0, 1'b0);

    // All equal minimum values: index 0 must win.
    for (int i = 0; i < 10; i++) v[i] = 8'h80;
    send_frame(0, v, 8'h00, 0, 1'b0);

    // Unsigned: 0xFF is the maximum.
    v[9] = 8'hFF;
    send_frame(1, v, 8'h00, 0, 1'b0);

    // Four lanes with 0x7F padding in the last word, which must be ignored.
    v = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05, 8'h09, 8'h0A};
    send_frame(1, v, 8'h7F, 0, 1'b0);

    // Five-cycle downstream stall with junk offered, then a fresh frame.
    rand_frame();
    send_frame(0, v, 8'h00, 5, 1'b0);
    for (int i = 0; i < 10; i++) v[i] = 8'(i + 20);
    v[2] = 8'h90;
    send_frame(0, v, 8'h00, 0, 1'b0);

    // Partial frame of large values, then reset, then frame 0..9.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      ival[0] = 1'b1;
      idata[0] = 32'h0000_007F;
    end
    do_reset();
    for (int i = 0; i < 10; i++) v[i] = 8'(i);
    send_frame(0, v, 8'h00, 0, 1'b0);

    // Random frames with idle gaps and random stalls on both instances.
    for (int f = 0; f < 20; f++) begin
      rand_frame();
      send_frame(0, v, 8'h00, $urandom_range(0, 3), 1'b1);
      rand_frame();
      send_frame(1, v, 8'($urandom), $urandom_range(0, 3), 1'b1);
    end

    // Back-to-back frames long enough to wrap the sequence counter.
    do_reset();
    for (int f = 0; f < 257; f++) begin
      rand_frame();
      send_frame(0, v, 8'h00, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
